alu_serial_seq: RTL and testbench

- Bit-serial sequencer that computes a WIDTH-bit RISC-V ALU operation on one shared 1-bit ALU slice (AND/OR/ADD/Less-mux slice with A/B invert), one bit per clock, LSB first.
- The slice has an explicit carry-in (slice_cin); this block owns the carry register and the operand/result shift registers.
- Two-pass sequencing for SLT: subtract pass, then Less-injection pass.
- Sits between the decode-side ALU request (start/ready/done handshake) and the slice instance, as a low-area ALU option.

---
 rtl/alu_serial_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_serial_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial RISC-V ALU sequencer. Drives one external 1-bit ALU slice
// (AND/OR/ADD/Less with A/B invert) one bit per clock, LSB first, and owns
// the carry register and the operand/result shift registers. SLT takes two
// passes: a subtract pass that forms the set bit, then a Less-injection pass.
// Optional macro ALU_SEQ_FLAGS_EN adds registered carry_out/overflow outputs.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             carry_out,
  output logic             overflow,
`endif
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_ainvert,
  output logic             slice_binvert,
  output logic [1:0]       slice_op,
  output logic             slice_less,
  output logic             slice_cin,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLT} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res_sh, r_result;
  logic [3:0]       r_ctrl;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_set, r_done, r_zero;

  logic             w_accept, w_last, w_is_slt, w_ovf, w_finish;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_cnt == CW'(WIDTH-1));
  assign w_is_slt   = (r_ctrl == CTRL_SLT);
  // carry into the MSB xor carry out of it; only meaningful on the last bit
  assign w_ovf      = r_carry ^ slice_cout;
  assign w_res_next = {slice_result, r_res_sh[WIDTH-1:1]};
  // completion of the whole operation (single pass, or second SLT pass)
  assign w_finish   = w_last && (((r_state == S_RUN) && !w_is_slt) || (r_state == S_SLT));

  assign ready  = (r_state == S_IDLE);
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = w_is_slt ? S_SLT : S_IDLE;
      S_SLT:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // slice drive; everything is held at 0 while idle
  always_comb begin
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_ainvert = 1'b0;
    slice_binvert = 1'b0;
    slice_op      = 2'b00;
    slice_less    = 1'b0;
    slice_cin     = 1'b0;
    if (r_state != S_IDLE) begin
      slice_a       = r_a_sh[0];
      slice_b       = r_b_sh[0];
      slice_ainvert = r_ctrl[3];
      slice_binvert = r_ctrl[2];
      slice_cin     = r_carry;
      if (r_state == S_RUN) begin
        // SLT's first pass is a plain subtract
        slice_op = w_is_slt ? 2'b10 : r_ctrl[1:0];
      end else begin
        slice_op   = 2'b11;
        slice_less = r_set && (r_cnt == '0);
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // datapath: operand/result shifting, carry, counter, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_result <= '0;
      r_ctrl   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_set    <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_ctrl  <= alu_ctrl;
        r_carry <= alu_ctrl[2];
        r_cnt   <= '0;
      end else if (r_state != S_IDLE) begin
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_res_sh <= w_res_next;
        r_carry  <= slice_cout;
        r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
        if ((r_state == S_RUN) && w_last && w_is_slt)
          r_set <= slice_result ^ w_ovf;
        if (w_finish) begin
          r_result <= w_res_next;
          r_zero   <= (w_res_next == '0);
        end
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_cout_p, r_ovf_p, r_flag_c, r_flag_v, w_arith;

  // only ADD/SUB-style passes (Operation=10) and SLT report flags
  assign w_arith   = (r_ctrl[1:0] == 2'b10);
  assign carry_out = r_flag_c;
  assign overflow  = r_flag_v;

  // flags of the arithmetic pass, published together with result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout_p <= 1'b0;
      r_ovf_p  <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else begin
      if ((r_state == S_RUN) && w_last && w_is_slt) begin
        r_cout_p <= slice_cout;
        r_ovf_p  <= w_ovf;
      end
      if (w_finish) begin
        if (r_state == S_SLT) begin
          r_flag_c <= r_cout_p;
          r_flag_v <= r_ovf_p;
        end else begin
          r_flag_c <= w_arith & slice_cout;
          r_flag_v <= w_arith & w_ovf;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice.
module tb_alu_serial_seq;
  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] a = '0, b = '0, result;
  logic         ready, busy, done, zero;
  logic         slice_a, slice_b, slice_ainvert, slice_binvert, slice_less, slice_cin;
  logic [1:0]   slice_op;
  logic         slice_result, slice_cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic         carry_out, overflow;
`endif

  int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0, lat, nd;
  logic cin0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result), .zero(zero),
`ifdef ALU_SEQ_FLAGS_EN
    .carry_out(carry_out), .overflow(overflow),
`endif
    .slice_a(slice_a), .slice_b(slice_b), .slice_ainvert(slice_ainvert),
    .slice_binvert(slice_binvert), .slice_op(slice_op), .slice_less(slice_less),
    .slice_cin(slice_cin), .slice_result(slice_result), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // behavioural 1-bit ALU slice
  logic sl_ae, sl_be;
  always_comb begin
    sl_ae        = slice_a ^ slice_ainvert;
    sl_be        = slice_b ^ slice_binvert;
    slice_cout   = (sl_ae & sl_be) | (sl_ae & slice_cin) | (sl_be & slice_cin);
    slice_result = 1'b0;
    case (slice_op)
      2'b00: slice_result = sl_ae & sl_be;
      2'b01: slice_result = sl_ae | sl_be;
      2'b10: slice_result = sl_ae ^ sl_be ^ slice_cin;
      default: slice_result = slice_less;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  // present a request from an idle cycle; returns after the accepting edge
  task automatic launch(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; alu_ctrl = c; a = av; b = bv;
    tick();
    start = 1'b0;
    t0 = cyc;
    cin0 = slice_cin;
  endtask

  // edges from acceptance to the cycle showing done (bounded)
  task automatic wait_done(output int l);
    while (!done && (cyc - t0) < 200) tick();
    l = cyc - t0;
  endtask

  task automatic run(input string tag, input logic [3:0] c, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic [W-1:0] exp, input int exp_lat);
    launch(c, av, bv);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_zero"}, zero, (exp == '0));
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    tick(); tick(); rst = 1'b0; tick();
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_slice", {slice_a, slice_b, slice_ainvert, slice_binvert, slice_op, slice_less, slice_cin}, '0);

    run("add", C_ADD, 32'd5, 32'd7, 32'd12, W);
    chk("add_cin0", cin0, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("add_c", carry_out, 1'b0);
`endif
    run("sub", C_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, W);
    chk("sub_cin0", cin0, 1'b1);
`ifdef ALU_SEQ_FLAGS_EN
    chk("sub_c", carry_out, 1'b0);
    chk("sub_v", overflow, 1'b0);
`endif
    run("slt_ovf", C_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 2*W);
`ifdef ALU_SEQ_FLAGS_EN
    chk("slt_v", overflow, 1'b1);
`endif
    run("slt_neg", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 2*W);
    run("slt_ge", C_SLT, 32'd9, 32'd2, 32'd0, 2*W);
    run("nor", C_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, W);
    run("and", C_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, W);
    run("or", C_OR, 32'h1234_5670, 32'h0000_000F, 32'h1234_567F, W);
    run("sub_eq", C_SUB, 32'd9, 32'd9, 32'd0, W);
    run("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, W);
`ifdef ALU_SEQ_FLAGS_EN
    chk("wrap_c", carry_out, 1'b1);
    chk("wrap_v", overflow, 1'b0);
`endif

    // back-to-back: start held high across done
    start = 1'b1; alu_ctrl = C_ADD; a = 32'd100; b = 32'd23;
    tick(); t0 = cyc;
    alu_ctrl = C_SUB; a = 32'd50; b = 32'd8;
    chk("b2b_ready_busy", ready, 1'b0);
    repeat (5) tick();
    chk("b2b_ready_mid", ready, 1'b0);
    wait_done(lat);
    chk("b2b1_lat", lat, W);
    chk("b2b1_res", result, 32'd123);
    tick(); t0 = cyc; start = 1'b0;
    chk("b2b2_busy", busy, 1'b1);
    wait_done(lat);
    chk("b2b2_lat", lat, W);
    chk("b2b2_res", result, 32'd42);

    // start pulse while busy is ignored
    tick();
    launch(C_ADD, 32'd1, 32'd2);
    repeat (5) tick();
    start = 1'b1; alu_ctrl = C_SUB; a = 32'd999; b = 32'd1;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", lat, W);
    chk("ign_res", result, 32'd3);
    nd = 0;
    repeat (6) begin tick(); if (done || busy) nd++; end
    chk("ign_no_extra", nd, 0);

    // reset at bit 10 of an ADD
    launch(C_ADD, 32'h10, 32'h20);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_result", result, '0);
    chk("mrst_zero", zero, 1'b1);
    nd = 0;
    repeat (W + 5) begin tick(); if (done) nd++; end
    chk("mrst_no_done", nd, 0);
    run("post_rst", C_ADD, 32'h10, 32'h20, 32'h30, W);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
